// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit -- pipeline hazard controller sitting after the ID/EX register.
// Resolves RAW hazards, taken-branch squashes and multi-cycle memory waits, and
// keeps a saturating stall-cycle counter plus a sticky memory-timeout flag.
// Optional feature macro: FORWARDING_EN (defined -> only load-use hazards stall,
// because a forwarding network covers every other dependency).
module hazard_ctrl_unit #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       id_src1,
  input  logic [3:0]       id_src2,
  input  logic             id_src1_used,
  input  logic             id_src2_used,
  input  logic [3:0]       ex_dest,
  input  logic             ex_wb_en,
  input  logic             ex_mem_read,
  input  logic [3:0]       mem_dest,
  input  logic             mem_wb_en,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             stat_clr,
  output logic             freeze_if,
  output logic             freeze_id,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             mem_stall,
  output logic [CNT_W-1:0] stall_count,
  output logic             timeout_err
);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  // Timer only needs to reach MEM_TIMEOUT; it parks there afterwards.
  localparam int TMR_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(MEM_TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MEM_TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               timeout_q, timeout_d;

  logic raw_ex;
  logic hazard;
  logic mem_wait;

  // RAW detection against the EX-stage producer (and MEM-stage without forwarding).
  assign raw_ex = ex_wb_en & ((id_src1_used & (id_src1 == ex_dest)) |
                              (id_src2_used & (id_src2 == ex_dest)));

`ifdef FORWARDING_EN
  // MEM-stage results are forwarded, so only a load in EX forces a bubble.
  logic unused_mem_fields;
  assign unused_mem_fields = ^{mem_dest, mem_wb_en};
  assign hazard = raw_ex & ex_mem_read;
`else
  logic raw_mem;
  assign raw_mem = mem_wb_en & ((id_src1_used & (id_src1 == mem_dest)) |
                                (id_src2_used & (id_src2 == mem_dest)));
  assign hazard  = raw_ex | raw_mem;
`endif

  // Memory wait is active on the entry cycle and every unfinished MEM_WAIT cycle.
  assign mem_wait = (state_q == RUN) ? (mem_req & ~mem_ready) : ~mem_ready;

  // Next-state and prioritised pipeline controls (memory wait > branch > hazard).
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_d    = state_q;
    freeze_if  = 1'b0;
    freeze_id  = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    mem_stall  = 1'b0;

    if (mem_wait) begin
      freeze_if = 1'b1;
      freeze_id = 1'b1;
      mem_stall = 1'b1;
    end else if (ex_branch_taken) begin
      // The ID instruction is squashed, so any hazard it carries is irrelevant.
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
    end else if (hazard) begin
      freeze_if  = 1'b1;
      flush_idex = 1'b1;
    end

    unique case (state_q)
      RUN:      if (mem_req && !mem_ready) state_d = MEM_WAIT;
      MEM_WAIT: if (mem_ready)             state_d = RUN;
      default:                             state_d = RUN;
    endcase

    // Controls drop as soon as reset asserts, without waiting for a clock edge.
    if (!rst) begin
      freeze_if  = 1'b0;
      freeze_id  = 1'b0;
      flush_ifid = 1'b0;
      flush_idex = 1'b0;
      mem_stall  = 1'b0;
    end
  end

  // Wait timer, stall counter and sticky timeout next values; stat_clr wins.
  always_comb begin
    timer_d     = timer_q;
    stall_cnt_d = stall_cnt_q;
    timeout_d   = timeout_q;

    if (state_q == RUN) begin
      timer_d = '0;
    end else if (timer_q != TMR_MAX) begin
      timer_d = timer_q + 1'b1;
    end

    if ((state_q == MEM_WAIT) && (timer_q == TMR_LAST)) begin
      timeout_d = 1'b1;
    end

    if (freeze_if && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end

    if (stat_clr) begin
      stall_cnt_d = '0;
      timeout_d   = 1'b0;
    end
  end

  // State and statistics registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      timer_q     <= '0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      timer_q     <= timer_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign stall_count = stall_cnt_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit -- table vectors, hand-written multi-cycle sequences and
// randomized traffic compared against a behavioural model of the controller.
module tb_hazard_ctrl_unit;

  localparam int CNT_W       = 5;
  localparam int MEM_TIMEOUT = 8;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [3:0]       id_src1, id_src2, ex_dest, mem_dest;
  logic             id_src1_used, id_src2_used, ex_wb_en, ex_mem_read, mem_wb_en;
  logic             ex_branch_taken, mem_req, mem_ready, stat_clr;
  logic             freeze_if, freeze_id, flush_ifid, flush_idex, mem_stall;
  logic [CNT_W-1:0] stall_count;
  logic             timeout_err;

  hazard_ctrl_unit #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_src1_used(id_src1_used), .id_src2_used(id_src2_used),
    .ex_dest(ex_dest), .ex_wb_en(ex_wb_en), .ex_mem_read(ex_mem_read),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .stat_clr(stat_clr),
    .freeze_if(freeze_if), .freeze_id(freeze_id), .flush_ifid(flush_ifid),
    .flush_idex(flush_idex), .mem_stall(mem_stall),
    .stall_count(stall_count), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] s1, s2, ed, md;
    logic       u1, u2, ewb, emr, mwb, br, mreq, mrdy, clr;
  } vin_t;

  typedef struct {
    vin_t       in;
    logic [4:0] ctl;  // {freeze_if, freeze_id, flush_ifid, flush_idex, mem_stall}
  } vec_t;

  localparam logic [4:0] C_NONE = 5'b00000;
  localparam logic [4:0] C_MEM  = 5'b11001;
  localparam logic [4:0] C_BR   = 5'b00110;
  localparam logic [4:0] C_HAZ  = 5'b10010;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: "waiting" flag, wait-cycle tally, stall tally, sticky error.
  bit m_wait = 1'b0;
  int m_wcyc = 0;
  int m_cnt  = 0;
  bit m_err  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [4:0] dut_ctl();
    return {freeze_if, freeze_id, flush_ifid, flush_idex, mem_stall};
  endfunction

  function automatic vin_t mk(input logic [3:0] s1, input logic u1, input logic [3:0] s2,
                              input logic u2, input logic [3:0] ed, input logic ewb,
                              input logic emr, input logic [3:0] md, input logic mwb,
                              input logic br, input logic mreq, input logic mrdy,
                              input logic clr);
    vin_t v;
    v.s1 = s1; v.u1 = u1; v.s2 = s2; v.u2 = u2; v.ed = ed; v.ewb = ewb; v.emr = emr;
    v.md = md; v.mwb = mwb; v.br = br; v.mreq = mreq; v.mrdy = mrdy; v.clr = clr;
    return v;
  endfunction

  // Expected controls straight from the priority rules.
  function automatic logic [4:0] model_ctl(input vin_t v, input bit waiting);
    bit busy   = waiting ? !v.mrdy : (v.mreq && !v.mrdy);
    bit dep_ex = v.ewb && ((v.u1 && v.s1 == v.ed) || (v.u2 && v.s2 == v.ed));
    bit haz;
`ifdef FORWARDING_EN
    haz = dep_ex && v.emr;
`else
    haz = dep_ex || (v.mwb && ((v.u1 && v.s1 == v.md) || (v.u2 && v.s2 == v.md)));
`endif
    if (busy)     return C_MEM;
    if (v.br)     return C_BR;
    if (haz)      return C_HAZ;
    return C_NONE;
  endfunction

  task automatic model_update(input vin_t v);
    logic [4:0] c = model_ctl(v, m_wait);
    if (v.clr) m_cnt = 0;
    else if (c[4] && m_cnt < CNT_MAX) m_cnt++;
    if (m_wait) begin
      m_wcyc++;
      if (m_wcyc == MEM_TIMEOUT) m_err = 1'b1;
    end
    if (v.clr) m_err = 1'b0;
    if (m_wait) m_wait = !v.mrdy;
    else if (v.mreq && !v.mrdy) begin
      m_wait = 1'b1;
      m_wcyc = 0;
    end
  endtask

  task automatic drive(input vin_t v);
    id_src1 = v.s1; id_src1_used = v.u1; id_src2 = v.s2; id_src2_used = v.u2;
    ex_dest = v.ed; ex_wb_en = v.ewb; ex_mem_read = v.emr;
    mem_dest = v.md; mem_wb_en = v.mwb; ex_branch_taken = v.br;
    mem_req = v.mreq; mem_ready = v.mrdy; stat_clr = v.clr;
    #1;
  endtask

  task automatic check_model(input string name, input vin_t v);
    check({name, ".ctl"}, 32'(dut_ctl()), 32'(model_ctl(v, m_wait)));
    check({name, ".cnt"}, 32'(stall_count), 32'(m_cnt));
    check({name, ".err"}, 32'(timeout_err), 32'(m_err));
  endtask

  task automatic tick(input vin_t v);
    model_update(v);
    @(posedge clk);
    #1;
  endtask

  // One cycle checked only against the model.
  task automatic step(input string name, input vin_t v);
    drive(v);
    check_model(name, v);
    tick(v);
  endtask

  // One cycle checked against a hand-derived control value and the model.
  task automatic step_exp(input string name, input vin_t v, input logic [4:0] exp);
    drive(v);
    check({name, ".hand"}, 32'(dut_ctl()), 32'(exp));
    check_model(name, v);
    tick(v);
  endtask

  vec_t vecs[12];
  vin_t idle, clr_v, lu, wait_v, wait_br, done_br, done_v;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle    = mk(0,0,0,0, 0,0,0, 0,0, 0,0,0, 0);
    clr_v   = mk(0,0,0,0, 0,0,0, 0,0, 0,0,0, 1);
    lu      = mk(3,1,0,0, 3,1,1, 0,0, 0,0,0, 0);
    wait_v  = mk(0,0,0,0, 0,0,0, 0,0, 0,1,0, 0);
    wait_br = mk(0,0,0,0, 0,0,0, 0,0, 1,1,0, 0);
    done_br = mk(0,0,0,0, 0,0,0, 0,0, 1,1,1, 0);
    done_v  = mk(0,0,0,0, 0,0,0, 0,0, 0,1,1, 0);

    // ---- Vector table (all applied from RUN) ----
    vecs[0]  = '{mk(3,1,0,0, 3,1,1, 0,0, 0,0,0, 0), C_HAZ};   // load-use
`ifdef FORWARDING_EN
    vecs[1]  = '{mk(3,1,0,0, 3,1,0, 0,0, 0,0,0, 0), C_NONE};  // ALU result forwarded
    vecs[2]  = '{mk(0,0,5,1, 9,0,0, 5,1, 0,0,0, 0), C_NONE};  // MEM producer forwarded
`else
    vecs[1]  = '{mk(3,1,0,0, 3,1,0, 0,0, 0,0,0, 0), C_HAZ};
    vecs[2]  = '{mk(0,0,5,1, 9,0,0, 5,1, 0,0,0, 0), C_HAZ};
`endif
    vecs[3]  = '{mk(3,1,0,0, 3,1,1, 0,0, 1,0,0, 0), C_BR};    // branch beats hazard
    vecs[4]  = '{mk(3,0,0,0, 3,1,1, 0,0, 0,0,0, 0), C_NONE};  // source not read
    vecs[5]  = '{mk(3,1,0,0, 3,0,1, 0,0, 0,0,0, 0), C_NONE};  // no write-back
    vecs[6]  = '{mk(0,0,15,1, 15,1,1, 0,0, 0,0,0, 0), C_HAZ}; // register 15
    vecs[7]  = '{mk(0,0,0,0, 0,0,0, 0,0, 0,1,1, 0), C_NONE};  // mem ready on entry
    vecs[8]  = '{mk(3,1,0,0, 3,1,1, 0,0, 0,1,1, 0), C_HAZ};   // ready entry + load-use
    vecs[9]  = '{idle, C_NONE};
    vecs[10] = '{mk(0,0,5,1, 9,0,0, 6,1, 0,0,0, 0), C_NONE};  // MEM dest mismatch
    vecs[11] = '{mk(0,0,0,0, 0,0,0, 0,0, 1,0,0, 0), C_BR};    // branch alone

    // ---- Reset ----
    drive(idle);
    @(posedge clk); @(posedge clk); #1;
    check("reset.ctl", 32'(dut_ctl()), 32'(C_NONE));
    check("reset.cnt", 32'(stall_count), 32'd0);
    check("reset.err", 32'(timeout_err), 32'd0);
    #2 rst = 1'b1;
    @(posedge clk); #1;

    // ---- Table ----
    for (int i = 0; i < 12; i++) begin
      step_exp($sformatf("vec%0d", i), vecs[i].in, vecs[i].ctl);
    end

    // ---- Load-use: stall_count 0 -> 1 ----
    step("lu.clr", clr_v);
    check("lu.cnt0", 32'(stall_count), 32'd0);
    step_exp("lu", lu, C_HAZ);
    check("lu.cnt1", 32'(stall_count), 32'd1);

    // ---- Memory wait: 4 frozen cycles, then ready, then RUN ----
    step("mw.clr", clr_v);
    for (int k = 0; k < 4; k++) step_exp($sformatf("mw.wait%0d", k), wait_v, C_MEM);
    step_exp("mw.ready", done_v, C_NONE);
    check("mw.cnt", 32'(stall_count), 32'd4);
    step_exp("mw.run", wait_v, C_MEM);  // fresh request from RUN stalls again
    step_exp("mw.ready2", done_v, C_NONE);
    step_exp("mw.idle", idle, C_NONE);

    // ---- Branch held during MEM_WAIT is seen on exit ----
    step_exp("br.enter", wait_v, C_MEM);
    step_exp("br.masked", wait_br, C_MEM);
    step_exp("br.exit", done_br, C_BR);
    step_exp("br.idle", idle, C_NONE);

    // ---- Timeout after the 8th MEM_WAIT cycle, then stat_clr ----
    step("to.clr", clr_v);
    step_exp("to.entry", wait_v, C_MEM);
    for (int k = 1; k <= MEM_TIMEOUT; k++) begin
      step_exp($sformatf("to.w%0d", k), wait_v, C_MEM);
      check($sformatf("to.err%0d", k), 32'(timeout_err), (k == MEM_TIMEOUT) ? 32'd1 : 32'd0);
    end
    step_exp("to.clr_wait", mk(0,0,0,0, 0,0,0, 0,0, 0,1,0, 1), C_MEM);
    check("to.err_clr", 32'(timeout_err), 32'd0);
    check("to.cnt_clr", 32'(stall_count), 32'd0);
    step_exp("to.more", wait_v, C_MEM);
    step_exp("to.exit", done_v, C_NONE);
    step_exp("to.idle", idle, C_NONE);

    // ---- Stall counter saturation ----
    step("sat.clr", clr_v);
    for (int k = 0; k < CNT_MAX + 4; k++) step("sat", lu);
    check("sat.cnt", 32'(stall_count), 32'(CNT_MAX));

    // ---- Reset in the middle of a wait ----
    step_exp("rw.enter", wait_v, C_MEM);
    step_exp("rw.wait", wait_v, C_MEM);
    drive(wait_v);
    #2 rst = 1'b0;
    #1;
    check("rw.ctl", 32'(dut_ctl()), 32'(C_NONE));
    check("rw.cnt", 32'(stall_count), 32'd0);
    m_wait = 1'b0; m_wcyc = 0; m_cnt = 0; m_err = 1'b0;
    drive(idle);
    rst = 1'b1;
    @(posedge clk); #1;
    step_exp("rw.run", idle, C_NONE);
    step_exp("rw.run2", idle, C_NONE);

    // ---- Randomized traffic against the model ----
    for (int i = 0; i < 3000; i++) begin
      vin_t v;
      v.s1   = 4'($urandom_range(0, 3));
      v.s2   = 4'($urandom_range(0, 3));
      v.ed   = 4'($urandom_range(0, 3));
      v.md   = 4'($urandom_range(0, 3));
      v.u1   = 1'($urandom);
      v.u2   = 1'($urandom);
      v.ewb  = 1'($urandom);
      v.emr  = 1'($urandom);
      v.mwb  = 1'($urandom);
      v.br   = ($urandom_range(0, 7) == 0);
      v.mreq = ($urandom_range(0, 3) == 0);
      v.mrdy = ($urandom_range(0, 2) == 0);
      v.clr  = ($urandom_range(0, 63) == 0);
      step("rand", v);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
